// File: rtl/apx_adder_err_monitor.sv
// Streaming exact vs. approximate adder evaluator with a 2-stage pipeline and per-run error statistics.
// Build option: define APX_ADDER_RND_EN to round the approximate sum instead of truncating it.
module apx_adder_err_monitor #(
    parameter int W       = 32,
    parameter int NAB     = 1,
    parameter int N_PAIRS = 500,
    parameter int CW      = 16,
    parameter int SW      = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_exact,
    output logic [W-1:0]  out_apx,
    output logic          out_mismatch,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] stat_pairs,
    output logic [CW-1:0] stat_mismatch,
    output logic [W:0]    stat_max_err,
    output logic [SW-1:0] stat_sum_err
);

    // state  | meaning
    // S_IDLE | after reset, waiting for start
    // S_RUN  | accepting pairs until N_PAIRS results have left
    // S_DONE | run complete, stats held until next start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] L_N   = CW'(N_PAIRS);
    localparam logic [CW-1:0] L_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t         r_state;
    logic [CW-1:0]  r_acc;
    logic [CW-1:0]  r_pairs;
    logic [CW-1:0]  r_mism;
    logic [W:0]     r_max;
    logic [SW-1:0]  r_sum;

    logic           r_s1_valid;
    logic [W:0]     r_s1_exact;
    logic [W:0]     r_s1_apx;
    logic           r_s2_valid;
    logic [W-1:0]   r_s2_exact;
    logic [W-1:0]   r_s2_apx;
    logic           r_s2_mism;
    logic [W:0]     r_s2_err;

    logic           w_out_fire;
    logic           w_s2_adv;
    logic           w_s1_adv;
    logic           w_in_fire;
    logic [W:0]     w_exact_full;
    logic [W:0]     w_apx_full;
    logic [W:0]     w_err;
    logic [SW:0]    w_sum_ext;

    assign w_out_fire = r_s2_valid & out_ready;
    assign w_s2_adv   = ~r_s2_valid | out_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign in_ready   = (r_state == S_RUN) && (r_acc < L_N) && w_s1_adv;
    assign w_in_fire  = in_valid & in_ready;

    assign w_exact_full = {1'b0, in_a} + {1'b0, in_b};

    generate
        if (NAB == 0) begin : g_exact
            assign w_apx_full = w_exact_full;
        end else begin : g_apx
            logic [W-NAB:0] w_hi;
            logic           w_rc;
`ifdef APX_ADDER_RND_EN
            assign w_rc = in_a[NAB-1] | in_b[NAB-1];
`else
            assign w_rc = 1'b0;
`endif
            assign w_hi = {1'b0, in_a[W-1:NAB]} + {1'b0, in_b[W-1:NAB]}
                        + {{(W-NAB){1'b0}}, w_rc};
            assign w_apx_full = {w_hi, {NAB{1'b0}}};
        end
    endgenerate

    // Rounding can push apx above exact, so the error is a true absolute difference.
    assign w_err = (r_s1_exact >= r_s1_apx) ? (r_s1_exact - r_s1_apx)
                                            : (r_s1_apx - r_s1_exact);

    assign w_sum_ext = {1'b0, r_sum} + {{(SW-W){1'b0}}, r_s2_err};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_exact <= '0;
            r_s1_apx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_exact <= '0;
            r_s2_apx   <= '0;
            r_s2_mism  <= 1'b0;
            r_s2_err   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_s1_exact <= w_exact_full;
                    r_s1_apx   <= w_apx_full;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_exact <= r_s1_exact[W-1:0];
                    r_s2_apx   <= r_s1_apx[W-1:0];
                    r_s2_mism  <= (r_s1_exact[W-1:0] != r_s1_apx[W-1:0]);
                    r_s2_err   <= w_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_pairs <= '0;
            r_mism  <= '0;
            r_max   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_acc   <= '0;
                        r_pairs <= '0;
                        r_mism  <= '0;
                        r_max   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    if (r_pairs == L_N) begin
                        r_state <= S_DONE;
                    end else begin
                        if (w_in_fire) r_acc <= r_acc + L_ONE;
                        if (w_out_fire) begin
                            r_pairs <= r_pairs + L_ONE;
                            r_mism  <= r_mism + {{(CW-1){1'b0}}, r_s2_mism};
                            if (r_s2_err > r_max) r_max <= r_s2_err;
                            r_sum   <= w_sum_ext[SW] ? {SW{1'b1}} : w_sum_ext[SW-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid     = r_s2_valid;
    assign out_exact     = r_s2_exact;
    assign out_apx       = r_s2_apx;
    assign out_mismatch  = r_s2_mism;
    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign stat_pairs    = r_pairs;
    assign stat_mismatch = r_mism;
    assign stat_max_err  = r_max;
    assign stat_sum_err  = r_sum;

endmodule

// File: tb/tb_apx_adder_err_monitor.sv
// Bench for apx_adder_err_monitor: NAB=4 and NAB=0 instances share one stimulus stream,
// checked against an arithmetic reference model (follows APX_ADDER_RND_EN when defined).
module tb_apx_adder_err_monitor;

    localparam int W = 32;
    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [31:0] in_a, in_b;

    logic        rdy4, ov4, mm4, busy4, done4;
    logic [31:0] ex4, ap4;
    logic [15:0] sp4, sm4;
    logic [32:0] smax4;
    logic [39:0] ssum4;

    logic        rdy0, ov0, mm0, busy0, done0;
    logic [31:0] ex0, ap0;
    logic [15:0] sp0, sm0;
    logic [32:0] smax0;
    logic [39:0] ssum0;

    apx_adder_err_monitor #(.W(W), .NAB(4), .N_PAIRS(NP), .CW(16), .SW(40)) u4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy4),
        .in_a(in_a), .in_b(in_b), .out_valid(ov4), .out_ready(out_ready),
        .out_exact(ex4), .out_apx(ap4), .out_mismatch(mm4), .busy(busy4), .done(done4),
        .stat_pairs(sp4), .stat_mismatch(sm4), .stat_max_err(smax4), .stat_sum_err(ssum4));

    apx_adder_err_monitor #(.W(W), .NAB(0), .N_PAIRS(NP), .CW(16), .SW(40)) u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .out_valid(ov0), .out_ready(out_ready),
        .out_exact(ex0), .out_apx(ap0), .out_mismatch(mm0), .busy(busy0), .done(done0),
        .stat_pairs(sp0), .stat_mismatch(sm0), .stat_max_err(smax0), .stat_sum_err(ssum0));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ex;
        logic [31:0] ap;
        logic        mm;
        logic [32:0] err;
    } exp_t;

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    exp_t        expq[$];
    longint      m_pairs, m_mism, m_max, m_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width sums in 64-bit arithmetic, approximate sum from the shifted-out operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int nab);
        longint unsigned la, lb, e, x, rc;
        exp_t r;
        la = longint'(a);
        lb = longint'(b);
        e  = la + lb;
        if (nab == 0) x = e;
        else begin
            rc = 0;
`ifdef APX_ADDER_RND_EN
            rc = ((la >> (nab - 1)) & 1) | ((lb >> (nab - 1)) & 1);
`endif
            x = ((la >> nab) + (lb >> nab) + rc) << nab;
        end
        r.ex  = e[31:0];
        r.ap  = x[31:0];
        r.mm  = (e[31:0] != x[31:0]);
        r.err = (e > x) ? 33'(e - x) : 33'(x - e);
        return r;
    endfunction

    task automatic clear_model();
        m_pairs = 0; m_mism = 0; m_max = 0; m_sum = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_model();
        #1;
        chk("start_pairs_clear", {48'b0, sp4}, 64'd0);
        chk("start_busy", {63'b0, busy4}, 64'd1);
        chk("start_done_low", {63'b0, done4}, 64'd0);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
    endtask

    task automatic run_stream(input int stall_at, input int stall_len, input int stop_outs,
                              input int start_at);
        int   cyc = 0;
        int   outs = 0;
        bit   hold = 1'b0;
        logic [31:0] h_ex, h_ap;
        logic h_mm;
        exp_t e, e0;
        while (outs < stop_outs && cyc < 300) begin
            @(negedge clk);
            out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            start     = (cyc == start_at);
            in_valid  = (qa.size() > 0);
            in_a      = (qa.size() > 0) ? qa[0] : 32'h0;
            in_b      = (qb.size() > 0) ? qb[0] : 32'h0;
            #1;
            if (hold) begin
                chk("hold_valid", {63'b0, ov4}, 64'd1);
                chk("hold_exact", {32'b0, ex4}, {32'b0, h_ex});
                chk("hold_apx", {32'b0, ap4}, {32'b0, h_ap});
                chk("hold_mismatch", {63'b0, mm4}, {63'b0, h_mm});
            end
            if (cyc == stall_at && qa.size() > 0)
                chk("stall_in_ready", {63'b0, rdy4}, 64'd0);
            if (in_valid && rdy4) begin
                expq.push_back(model(in_a, in_b, 4));
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (ov4 && out_ready) begin
                chk("out_expected_pending", {63'b0, (expq.size() > 0)}, 64'd1);
                if (expq.size() > 0) begin
                    e  = expq.pop_front();
                    e0 = model(e.ex, 32'h0, 0);
                    chk("out_exact", {32'b0, ex4}, {32'b0, e.ex});
                    chk("out_apx", {32'b0, ap4}, {32'b0, e.ap});
                    chk("out_mismatch", {63'b0, mm4}, {63'b0, e.mm});
                    chk("nab0_apx", {32'b0, ap0}, {32'b0, e0.ap});
                    chk("nab0_mismatch", {63'b0, mm0}, 64'd0);
                    m_pairs++;
                    m_mism += longint'(e.mm);
                    if (longint'(e.err) > m_max) m_max = longint'(e.err);
                    m_sum += longint'(e.err);
                end
                outs++;
            end
            hold = ov4 && !out_ready;
            h_ex = ex4; h_ap = ap4; h_mm = mm4;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 300) chk("stream_timeout", 64'd1, 64'd0);
    endtask

    task automatic finish_run();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("end_pairs", {48'b0, sp4}, 64'(m_pairs));
        chk("end_done_not_yet", {63'b0, done4}, 64'd0);
        @(negedge clk);
        #1;
        chk("end_done", {63'b0, done4}, 64'd1);
        chk("end_busy", {63'b0, busy4}, 64'd0);
        chk("end_mismatch", {48'b0, sm4}, 64'(m_mism));
        chk("end_max_err", {31'b0, smax4}, 64'(m_max));
        chk("end_sum_err", {24'b0, ssum4}, 64'(m_sum));
        chk("nab0_pairs", {48'b0, sp0}, 64'(m_pairs));
        chk("nab0_stat_mismatch", {48'b0, sm0}, 64'd0);
        chk("nab0_sum", {24'b0, ssum0}, 64'd0);
        chk("nab0_done", {63'b0, done0}, 64'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = 32'h0; in_b = 32'h0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'b0, ov4}, 64'd0);
        chk("rst_in_ready", {63'b0, rdy4}, 64'd0);
        chk("rst_busy", {63'b0, busy4}, 64'd0);
        chk("rst_done", {63'b0, done4}, 64'd0);
        chk("rst_pairs", {48'b0, sp4}, 64'd0);
        chk("rst_sum", {24'b0, ssum4}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // in_valid while idle must be ignored
        in_valid = 1'b1; in_a = 32'h1234; in_b = 32'h8;
        #1;
        chk("idle_in_ready", {63'b0, rdy4}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("idle_pairs", {48'b0, sp4}, 64'd0);
        chk("idle_out_valid", {63'b0, ov4}, 64'd0);
        in_valid = 1'b0;

        // run 1: directed corner operands plus two random pairs
        qa.push_back(32'h0000000F); qb.push_back(32'h00000001);
        qa.push_back(32'hFFFFFFFF); qb.push_back(32'h00000001);
        push_random(2);
        do_start();
        run_stream(-1, 0, NP, -1);
        finish_run();

        // run 2: restart from DONE, backpressure stall, ignored start mid-run
        push_random(NP);
        do_start();
        run_stream(3, 5, NP, 1);
        finish_run();

        // run 3: asynchronous reset after two outputs
        push_random(NP);
        do_start();
        run_stream(-1, 0, 2, -1);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, ov4}, 64'd0);
        chk("arst_busy", {63'b0, busy4}, 64'd0);
        chk("arst_pairs", {48'b0, sp4}, 64'd0);
        chk("arst_max", {31'b0, smax4}, 64'd0);
        chk("arst_sum", {24'b0, ssum4}, 64'd0);
        chk("arst_exact", {32'b0, ex4}, 64'd0);
        qa.delete(); qb.delete(); expq.delete();
        clear_model();
        @(negedge clk);
        rst = 1'b1;

        // run 4: fresh run after reset
        push_random(NP);
        do_start();
        run_stream(-1, 0, NP, -1);
        finish_run();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
